// File: rtl/native_mem_bridge_pkg.sv
// rtl/native_mem_bridge_pkg.sv - shared types and constants for the native memory bridge
package native_mem_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_CAPT,
    S_RESP
  } state_t;

  localparam int          WAIT_CNT_W = 4;
  localparam logic [31:0] OOR_RDATA  = 32'h0000_0000;

endpackage

// File: rtl/mem_bridge_wait_ctr.sv
// rtl/mem_bridge_wait_ctr.sv - loadable down-counter with zero flag for the bridge WAIT state
module mem_bridge_wait_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Saturates at zero so it idles harmlessly outside the WAIT state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/native_mem_bridge.sv
// rtl/native_mem_bridge.sv - picorv32 native port to 1-cycle SRAM handshake bridge
// Optional out-of-range detection enabled by macro NATIVE_MEM_BRIDGE_OOR_EN.
module native_mem_bridge
  import native_mem_bridge_pkg::*;
#(
  parameter int WORDS       = 32,
  parameter int ADDR_W      = 5,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_valid,
  input  logic              cpu_instr,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              err_clr,
  output logic              err_valid,
  output logic [31:0]       err_addr
);

  localparam logic [ADDR_W-1:0]     ADDR_MASK = ADDR_W'(WORDS - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              oor_q;
  logic              oor_hit;
  logic              accept;
  logic              is_read;
  logic              wait_zero;

  assign accept  = (state == S_IDLE) && cpu_valid;
  assign is_read = (wstrb_q == 4'h0);

  mem_bridge_wait_ctr #(.W(WAIT_CNT_W)) u_wait_ctr (
    .clk      (clk),
    .resetn   (resetn),
    .load     (state == S_ACCESS),
    .load_val (WAIT_LOAD),
    .zero     (wait_zero)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cpu_valid) state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (WAIT_CYCLES > 0) state_nxt = S_WAIT;
        else                 state_nxt = is_read ? S_CAPT : S_RESP;
      end
      S_WAIT:   if (wait_zero) state_nxt = is_read ? S_CAPT : S_RESP;
      S_CAPT:   state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Request fields are captured once at acceptance and held until the next IDLE accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      oor_q     <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      if (accept) begin
        addr_q  <= cpu_addr[ADDR_W+1:2] & ADDR_MASK;
        wdata_q <= cpu_wdata;
        wstrb_q <= cpu_wstrb;
        oor_q   <= oor_hit;
      end
      if (state == S_CAPT) begin
        cpu_rdata <= oor_q ? OOR_RDATA : ram_rdata;
      end
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_wen   = ((state == S_ACCESS) && !oor_q) ? wstrb_q : 4'h0;
  assign cpu_ready = (state == S_RESP);

`ifdef NATIVE_MEM_BRIDGE_OOR_EN
  logic err_set;
  logic unused_ok;

  assign oor_hit   = |cpu_addr[31:ADDR_W+2];
  assign err_set   = accept && oor_hit;
  assign unused_ok = &{1'b0, cpu_instr, cpu_addr[1:0]};

  // A new error takes priority over a simultaneous clear; only the first address is kept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else begin
      if (err_set && !err_valid) err_addr <= cpu_addr;
      if (err_set)               err_valid <= 1'b1;
      else if (err_clr)          err_valid <= 1'b0;
    end
  end
`else
  logic unused_ok;

  assign oor_hit   = 1'b0;
  assign err_valid = 1'b0;
  assign err_addr  = '0;
  assign unused_ok = &{1'b0, cpu_instr, err_clr, cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};
`endif

endmodule

// File: tb/tb_native_mem_bridge.sv
// tb/tb_native_mem_bridge.sv - scoreboard bench for native_mem_bridge (WAIT_CYCLES 0 and 3)
module tb_native_mem_bridge;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    int          issue;
    int          lat;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        cpu_valid [2];
  logic        cpu_instr [2];
  logic [31:0] cpu_addr  [2];
  logic [31:0] cpu_wdata [2];
  logic [3:0]  cpu_wstrb [2];
  logic        cpu_ready [2];
  logic [31:0] cpu_rdata [2];
  logic [3:0]  ram_wen   [2];
  logic [4:0]  ram_addr  [2];
  logic [31:0] ram_wdata [2];
  logic [31:0] ram_rdata [2];
  logic        err_clr   [2];
  logic        err_valid [2];
  logic [31:0] err_addr  [2];

  int   cyc;
  int   checks;
  int   passes;
  exp_t q0[$];
  exp_t q1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [32];
    logic [31:0] rd;

    native_mem_bridge #(
      .WORDS       (32),
      .ADDR_W      (5),
      .WAIT_CYCLES ((g == 0) ? 0 : 3)
    ) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .cpu_valid (cpu_valid[g]),
      .cpu_instr (cpu_instr[g]),
      .cpu_addr  (cpu_addr[g]),
      .cpu_wdata (cpu_wdata[g]),
      .cpu_wstrb (cpu_wstrb[g]),
      .cpu_ready (cpu_ready[g]),
      .cpu_rdata (cpu_rdata[g]),
      .ram_wen   (ram_wen[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (ram_rdata[g]),
      .err_clr   (err_clr[g]),
      .err_valid (err_valid[g]),
      .err_addr  (err_addr[g])
    );

    initial for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 | i;

    always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[g][b]) mem[ram_addr[g]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
      rd <= mem[ram_addr[g]];
    end

    assign ram_rdata[g] = rd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic txn(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                     input logic [3:0] exp_wen, input logic [4:0] exp_raddr, input int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    cpu_valid[k] = 1'b1;
    cpu_addr[k]  = addr;
    cpu_wdata[k] = wdata;
    cpu_wstrb[k] = wstrb;
    e.is_read = (wstrb == 4'h0);
    e.rdata   = exp_rdata;
    e.issue   = cyc;
    e.lat     = lat;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(negedge clk);
    chk("access_ram_wen", ram_wen[k], exp_wen);
    chk("access_ram_addr", ram_addr[k], exp_raddr);
    chk("access_ram_wdata", ram_wdata[k], wdata);
    n = 0;
    while (!cpu_ready[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_seen", cpu_ready[k], 1'b1);
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    cpu_valid[k] = 1'b0;
    cpu_wstrb[k] = 4'h0;
  endtask

  initial begin : monitor
    exp_t e;
    logic have;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (resetn && cpu_ready[k]) begin
          have = 1'b0;
          if (k == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            have = 1'b1;
          end else if (k == 1 && q1.size() > 0) begin
            e = q1.pop_front();
            have = 1'b1;
          end
          chk("resp_expected", have, 1'b1);
          if (have) begin
            chk("latency", cyc - e.issue, e.lat);
            if (e.is_read) chk("rdata", cpu_rdata[k], e.rdata);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    checks = 0;
    passes = 0;
    cyc    = 0;
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cpu_valid[k] = 1'b0;
      cpu_instr[k] = 1'b0;
      cpu_addr[k]  = '0;
      cpu_wdata[k] = '0;
      cpu_wstrb[k] = '0;
      err_clr[k]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_cpu_ready", cpu_ready[k], 1'b0);
      chk("rst_cpu_rdata", cpu_rdata[k], 32'h0);
      chk("rst_ram_wen", ram_wen[k], 4'h0);
      chk("rst_ram_addr", ram_addr[k], 5'd0);
      chk("rst_err_valid", err_valid[k], 1'b0);
      chk("rst_err_addr", err_addr[k], 32'h0);
    end
    resetn = 1'b1;

    // Reset asserted while a full-word write sits in ACCESS.
    @(negedge clk);
    cpu_valid[0] = 1'b1;
    cpu_addr[0]  = 32'h0C;
    cpu_wdata[0] = 32'hDEADBEEF;
    cpu_wstrb[0] = 4'hF;
    @(negedge clk);
    chk("t1_access_wen", ram_wen[0], 4'hF);
    resetn = 1'b0;
    cpu_valid[0] = 1'b0;
    cpu_wstrb[0] = 4'h0;
    #1;
    chk("t1_rst_wen", ram_wen[0], 4'h0);
    chk("t1_rst_ready", cpu_ready[0], 1'b0);
    chk("t1_rst_addr", ram_addr[0], 5'd0);
    chk("t1_rst_wdata", ram_wdata[0], 32'h0);
    chk("t1_rst_rdata", cpu_rdata[0], 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    txn(0, 32'h0C, 32'h0, 4'h0, 32'hA5A50003, 4'h0, 5'd3, 3);
    idle(0);

    // Full write, read back, byte-lane merge, rdata hold across a write.
    txn(0, 32'h08, 32'hCAFEBABE, 4'hF, 32'h0, 4'hF, 5'd2, 2);
    txn(0, 32'h08, 32'h0, 4'h0, 32'hCAFEBABE, 4'h0, 5'd2, 3);
    txn(0, 32'h08, 32'h00110000, 4'b0100, 32'h0, 4'b0100, 5'd2, 2);
    txn(0, 32'h08, 32'h0, 4'h0, 32'hCA11BABE, 4'h0, 5'd2, 3);
    txn(0, 32'h14, 32'h00000055, 4'h1, 32'h0, 4'h1, 5'd5, 2);
    idle(0);
    @(negedge clk);
    chk("rdata_hold", cpu_rdata[0], 32'hCA11BABE);

`ifdef NATIVE_MEM_BRIDGE_OOR_EN
    txn(0, 32'h80, 32'h12345678, 4'hF, 32'h0, 4'h0, 5'd0, 2);
    chk("oor_err_valid", err_valid[0], 1'b1);
    chk("oor_err_addr", err_addr[0], 32'h80);
    txn(0, 32'h84, 32'h0, 4'h0, 32'h0, 4'h0, 5'd1, 3);
    idle(0);
    chk("oor_err_addr_kept", err_addr[0], 32'h80);
    @(negedge clk);
    err_clr[0] = 1'b1;
    @(negedge clk);
    err_clr[0] = 1'b0;
    chk("oor_err_cleared", err_valid[0], 1'b0);
    txn(0, 32'h00, 32'h0, 4'h0, 32'hA5A50000, 4'h0, 5'd0, 3);
    idle(0);
`else
    txn(0, 32'h80, 32'h12345678, 4'hF, 32'h0, 4'hF, 5'd0, 2);
    txn(0, 32'h00, 32'h0, 4'h0, 32'h12345678, 4'h0, 5'd0, 3);
    idle(0);
    chk("wrap_err_valid", err_valid[0], 1'b0);
`endif

    // Three wait states, then back-to-back reads with no bubble.
    txn(1, 32'h00, 32'h0, 4'h0, 32'hA5A50000, 4'h0, 5'd0, 6);
    idle(1);
    txn(1, 32'h10, 32'h11223344, 4'hF, 32'h0, 4'hF, 5'd4, 5);
    txn(1, 32'h10, 32'h0, 4'h0, 32'h11223344, 4'h0, 5'd4, 6);
    txn(1, 32'h04, 32'h0, 4'h0, 32'hA5A50001, 4'h0, 5'd1, 6);
    idle(1);

    repeat (4) @(negedge clk);
    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
